// File: rtl/spi_pkg.sv
// Shared types and mode constants for the SPI slave core.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_state_e;

  // {CPOL, CPHA} pairs for the four standard SPI modes.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchroniser bringing one asynchronous SPI pin into the clk domain.
module spi_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; the oldest stage is the synchronised output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// Parametrised SPI slave: oversampled pins, configurable CPOL/CPHA/width/bit order,
// one-entry tx buffer with valid/ready, underrun and mid-word abort reporting.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter logic        CPOL        = 1'b0,
  parameter logic        CPHA        = 1'b0,
  parameter logic        MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              underrun,
  output logic              frame_abort,
  output logic [7:0]        word_cnt
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_s, cs_n_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d_i(cs_n), .q_o(cs_n_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(mosi), .q_o(mosi_s)
  );

  logic sclk_prev_q, cs_n_prev_q;

  // One-cycle delayed copies for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_q <= CPOL;
      cs_n_prev_q <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_n_prev_q <= cs_n_s;
    end
  end

  logic sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge, cs_fall, cs_rise;

  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_n_s & cs_n_prev_q;
  assign cs_rise     = cs_n_s & ~cs_n_prev_q;

  spi_state_e          state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                underrun_q, underrun_d;
  logic                frame_abort_q, frame_abort_d;
  logic [7:0]          word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                buf_full_q, buf_full_d;

  logic                word_done, load_en, abort, tx_write;
  logic [DATA_W-1:0]   rx_word_next;

  assign rx_word_next = MSB_FIRST ? {rx_sr_q[DATA_W-2:0], mosi_s}
                                  : {mosi_s, rx_sr_q[DATA_W-1:1]};
  assign tx_write     = tx_valid & ~buf_full_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    word_done = 1'b0;
    load_en   = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        if (cs_rise) begin
          state_d = IDLE;
          abort   = (bit_cnt_q != '0);
        end else begin
          load_en = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sample_edge && (bit_cnt_q == LAST_BIT)) begin
          word_done = 1'b1;
          state_d   = LOAD;
        end
        // A cs_n rise coinciding with the final sample still completes the word.
        if (cs_rise) begin
          state_d = IDLE;
          abort   = ~word_done & (bit_cnt_q != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: shift registers, tx buffer, counters and pulses.
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    underrun_d    = 1'b0;
    frame_abort_d = abort;
    word_cnt_d    = word_cnt_q;
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;

    if (tx_write) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    if ((state_q == IDLE) && cs_fall) begin
      word_cnt_d = '0;
      bit_cnt_d  = '0;
    end

    if (load_en) begin
      bit_cnt_d = '0;
      if (buf_full_q) begin
        tx_sr_d    = buf_q;
        buf_full_d = 1'b0;
      end else if (tx_write) begin
        tx_sr_d    = tx_data;
        buf_full_d = 1'b0;
      end else begin
        tx_sr_d    = '0;
        underrun_d = 1'b1;
      end
    end

    if (state_q == SHIFT) begin
      if (sample_edge) begin
        rx_sr_d   = rx_word_next;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (word_done) begin
          rx_data_d  = rx_word_next;
          rx_valid_d = 1'b1;
          word_cnt_d = word_cnt_q + 8'd1;
          bit_cnt_d  = '0;
        end
      end
      // bit_cnt==0 marks both the CPHA=1 first leading edge and the CPHA=0 trailing
      // edge left over from the previous word; neither may advance the fresh word.
      if (shift_edge && (bit_cnt_q != '0)) begin
        tx_sr_d = MSB_FIRST ? {tx_sr_q[DATA_W-2:0], 1'b0}
                            : {1'b0, tx_sr_q[DATA_W-1:1]};
      end
    end

    if ((state_d == IDLE) && (state_q != IDLE)) begin
      bit_cnt_d = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      underrun_q    <= 1'b0;
      frame_abort_q <= 1'b0;
      word_cnt_q    <= '0;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      underrun_q    <= underrun_d;
      frame_abort_q <= frame_abort_d;
      word_cnt_q    <= word_cnt_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
    end
  end

  assign miso_oe     = ~cs_n_s;
  assign miso        = miso_oe & (MSB_FIRST ? tx_sr_q[DATA_W-1] : tx_sr_q[0]);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = ~buf_full_q;
  assign busy        = (state_q != IDLE);
  assign underrun    = underrun_q;
  assign frame_abort = frame_abort_q;
  assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: two instances (8-bit mode 0 MSB-first, 12-bit mode 3
// LSB-first) share one master bus; a scoreboard checks received words, MISO words,
// underrun/abort pulses, handshake state and reset behaviour.
module tb_spi_slave_core;

  localparam int unsigned W0 = 8;
  localparam int unsigned W1 = 12;
  localparam int unsigned SS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ph = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic sclk0, sclk1;

  assign sclk0 = ph;
  assign sclk1 = ~ph;

  logic          miso0, oe0, rxv0, txv0, txr0, busy0, und0, abt0;
  logic [W0-1:0] rxd0, txd0;
  logic [7:0]    wc0;
  logic          miso1, oe1, rxv1, txv1, txr1, busy1, und1, abt1;
  logic [W1-1:0] rxd1, txd1;
  logic [7:0]    wc1;

  spi_slave_core #(.DATA_W(W0), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(SS)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk0), .cs_n(cs_n), .mosi(mosi),
    .miso(miso0), .miso_oe(oe0), .rx_data(rxd0), .rx_valid(rxv0),
    .tx_data(txd0), .tx_valid(txv0), .tx_ready(txr0), .busy(busy0),
    .underrun(und0), .frame_abort(abt0), .word_cnt(wc0)
  );

  spi_slave_core #(.DATA_W(W1), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(SS)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk1), .cs_n(cs_n), .mosi(mosi),
    .miso(miso1), .miso_oe(oe1), .rx_data(rxd1), .rx_valid(rxv1),
    .tx_data(txd1), .tx_valid(txv1), .tx_ready(txr1), .busy(busy1),
    .underrun(und1), .frame_abort(abt1), .word_cnt(wc1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  wc;
  } rx_exp_t;

  rx_exp_t     rxq0[$], rxq1[$];
  logic [31:0] drvq0[$], drvq1[$];
  logic [31:0] sup0[$], sup1[$];
  logic        bits_q[$];
  logic        cap0[$], cap1[$];
  int          ucnt0 = 0, ucnt1 = 0, acnt0 = 0, acnt1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // tx drivers: offer a word only while the buffer is empty, so every offer is taken.
  initial begin
    logic [31:0] t;
    txv0 = 1'b0;
    txd0 = '0;
    forever begin
      @(negedge clk);
      if (rst_n && txr0 && (drvq0.size() > 0)) begin
        t    = drvq0.pop_front();
        txd0 = t[W0-1:0];
        txv0 = 1'b1;
      end else begin
        txv0 = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] t;
    txv1 = 1'b0;
    txd1 = '0;
    forever begin
      @(negedge clk);
      if (rst_n && txr1 && (drvq1.size() > 0)) begin
        t    = drvq1.pop_front();
        txd1 = t[W1-1:0];
        txv1 = 1'b1;
      end else begin
        txv1 = 1'b0;
      end
    end
  end

  // Monitors: pop the scoreboard on each rx_valid and count pulse outputs.
  initial begin
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rxv0 === 1'b1) begin
          if (rxq0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx0_unexpected: got rx_data 0x%0h, expected no word", rxd0);
          end else begin
            e = rxq0.pop_front();
            chk("rx0_data", 32'(rxd0), e.data);
            chk("rx0_word_cnt", 32'(wc0), 32'(e.wc));
          end
        end
        if (und0 === 1'b1) ucnt0++;
        if (abt0 === 1'b1) acnt0++;
      end
    end
  end

  initial begin
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rxv1 === 1'b1) begin
          if (rxq1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx1_unexpected: got rx_data 0x%0h, expected no word", rxd1);
          end else begin
            e = rxq1.pop_front();
            chk("rx1_data", 32'(rxd1), e.data);
            chk("rx1_word_cnt", 32'(wc1), 32'(e.wc));
          end
        end
        if (und1 === 1'b1) ucnt1++;
        if (abt1 === 1'b1) acnt1++;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_miso0"}, 32'(miso0), 0);
    chk({tag, "_oe0"}, 32'(oe0), 0);
    chk({tag, "_rxd0"}, 32'(rxd0), 0);
    chk({tag, "_rxv0"}, 32'(rxv0), 0);
    chk({tag, "_busy0"}, 32'(busy0), 0);
    chk({tag, "_und0"}, 32'(und0), 0);
    chk({tag, "_abt0"}, 32'(abt0), 0);
    chk({tag, "_wc0"}, 32'(wc0), 0);
    chk({tag, "_txr0"}, 32'(txr0), 1);
    chk({tag, "_miso1"}, 32'(miso1), 0);
    chk({tag, "_oe1"}, 32'(oe1), 0);
    chk({tag, "_rxd1"}, 32'(rxd1), 0);
    chk({tag, "_rxv1"}, 32'(rxv1), 0);
    chk({tag, "_busy1"}, 32'(busy1), 0);
    chk({tag, "_und1"}, 32'(und1), 0);
    chk({tag, "_abt1"}, 32'(abt1), 0);
    chk({tag, "_wc1"}, 32'(wc1), 0);
    chk({tag, "_txr1"}, 32'(txr1), 1);
  endtask

  task automatic push_tx0(input logic [31:0] w);
    logic [31:0] m;
    m = w & ((32'd1 << W0) - 32'd1);
    drvq0.push_back(m);
    sup0.push_back(m);
  endtask

  task automatic push_tx1(input logic [31:0] w);
    logic [31:0] m;
    m = w & ((32'd1 << W1) - 32'd1);
    drvq1.push_back(m);
    sup1.push_back(m);
  endtask

  task automatic push_bits(input logic [31:0] v, input int n, input bit lsb_first);
    for (int i = 0; i < n; i++) bits_q.push_back(lsb_first ? v[i] : v[n-1-i]);
  endtask

  task automatic push_rand_bits(input int n);
    for (int i = 0; i < n; i++) bits_q.push_back(1'($urandom_range(0, 1)));
  endtask

  // One master frame over bits_q. reset_bit >= 0 pulses rst_n during that bit.
  task automatic run_frame(input int reset_bit);
    int          nbits = bits_q.size();
    int          nw0 = nbits / W0;
    int          nw1 = nbits / W1;
    int          eu0 = 0, eu1 = 0;
    int          u0, u1, a0, a1;
    bit          rst_done = 1'b0;
    logic [31:0] w;
    logic [31:0] etx0[$], etx1[$];
    rx_exp_t     e;

    repeat (4) @(negedge clk);

    if (reset_bit < 0) begin
      // Expected receive words straight from the bit stream.
      for (int k = 0; k < nw0; k++) begin
        w = '0;
        for (int i = 0; i < W0; i++) if (bits_q[k*W0+i]) w = w | (32'd1 << (W0-1-i));
        e.data = w;
        e.wc   = 8'(k + 1);
        rxq0.push_back(e);
      end
      for (int k = 0; k < nw1; k++) begin
        w = '0;
        for (int i = 0; i < W1; i++) if (bits_q[k*W1+i]) w = w | (32'd1 << i);
        e.data = w;
        e.wc   = 8'(k + 1);
        rxq1.push_back(e);
      end
      // Each started word (completed ones plus the one begun afterwards) takes a buffer entry.
      for (int l = 0; l <= nw0; l++) begin
        if (sup0.size() > 0) etx0.push_back(sup0.pop_front());
        else begin
          etx0.push_back(32'd0);
          eu0++;
        end
      end
      for (int l = 0; l <= nw1; l++) begin
        if (sup1.size() > 0) etx1.push_back(sup1.pop_front());
        else begin
          etx1.push_back(32'd0);
          eu1++;
        end
      end
    end

    u0 = ucnt0; u1 = ucnt1; a0 = acnt0; a1 = acnt1;
    cap0.delete();
    cap1.delete();

    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; (i < nbits) && !rst_done; i++) begin
      mosi = bits_q[i];
      repeat (4) @(negedge clk);
      cap0.push_back(miso0);
      if (i == 0) begin
        chk("miso_oe0_active", 32'(oe0), 1);
        chk("miso_oe1_active", 32'(oe1), 1);
      end
      ph = 1'b1;
      repeat (4) @(negedge clk);
      if (i == reset_bit) begin
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        drvq0.delete(); drvq1.delete();
        sup0.delete();  sup1.delete();
        ph = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rst_done = 1'b1;
      end else begin
        repeat (4) @(negedge clk);
        cap1.push_back(miso1);
        ph = 1'b0;
        repeat (4) @(negedge clk);
      end
    end
    bits_q.delete();

    if (rst_done) begin
      repeat (8) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
      cs_n = 1'b1;
      repeat (SS + 2) @(posedge clk);
      #1;
      chk("busy0_after_cs_rise", 32'(busy0), 0);
      chk("busy1_after_cs_rise", 32'(busy1), 0);
      repeat (8) @(negedge clk);
      chk("underrun0_pulses", 32'(ucnt0 - u0), 32'(eu0));
      chk("underrun1_pulses", 32'(ucnt1 - u1), 32'(eu1));
      chk("abort0_pulses", 32'(acnt0 - a0), ((nbits % W0) != 0) ? 32'd1 : 32'd0);
      chk("abort1_pulses", 32'(acnt1 - a1), ((nbits % W1) != 0) ? 32'd1 : 32'd0);
      chk("rx0_missing", 32'(rxq0.size()), 0);
      chk("rx1_missing", 32'(rxq1.size()), 0);
      chk("tx_ready0", 32'(txr0), (sup0.size() == 0) ? 32'd1 : 32'd0);
      chk("tx_ready1", 32'(txr1), (sup1.size() == 0) ? 32'd1 : 32'd0);
      for (int k = 0; k < nw0; k++) begin
        w = '0;
        for (int i = 0; i < W0; i++) if (cap0[k*W0+i]) w = w | (32'd1 << (W0-1-i));
        chk("miso0_word", w, etx0[k]);
      end
      for (int k = 0; k < nw1; k++) begin
        w = '0;
        for (int i = 0; i < W1; i++) if (cap1[k*W1+i]) w = w | (32'd1 << i);
        chk("miso1_word", w, etx1[k]);
      end
      rxq0.delete();
      rxq1.delete();
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int n, s0, s1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Buffers never written: every load underruns and MISO stays 0.
    push_rand_bits(24);
    run_frame(-1);

    // 0xA5 received while 0x3C is transmitted (dut1 sees a partial word).
    push_tx0(32'h3C);
    push_tx1(32'h9C1);
    push_bits(32'hA5, 8, 1'b0);
    run_frame(-1);

    // 0x5A3 sent LSB-first for the 12-bit LSB-first instance.
    push_tx0(32'h81);
    push_tx1(32'h5A3);
    push_tx1(32'h0F0);
    push_bits(32'h5A3, 12, 1'b1);
    run_frame(-1);

    // cs_n rises after 5 bits: abort, buffer keeps its queued word.
    push_tx0(32'h11); push_tx0(32'h22);
    push_tx1(32'h333); push_tx1(32'h444);
    push_rand_bits(5);
    run_frame(-1);

    // Back-to-back words with refill across several frames.
    push_tx0(32'h12); push_tx0(32'h34); push_tx0(32'hBE); push_tx0(32'hEF);
    push_tx1(32'h123); push_tx1(32'hBEE);
    push_rand_bits(24);
    run_frame(-1);

    for (int f = 0; f < 8; f++) begin
      n  = $urandom_range(1, 40);
      s0 = $urandom_range(0, 5);
      s1 = $urandom_range(0, 4);
      for (int i = 0; i < s0; i++) push_tx0($urandom);
      for (int i = 0; i < s1; i++) push_tx1($urandom);
      push_rand_bits(n);
      run_frame(-1);
    end

    // Reset mid-word, then a clean frame.
    push_tx0(32'h5E);
    push_tx1(32'h7AB);
    push_rand_bits(12);
    run_frame(5);
    for (int i = 0; i < 4; i++) push_tx0($urandom);
    for (int i = 0; i < 3; i++) push_tx1($urandom);
    push_rand_bits(24);
    run_frame(-1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
